mem_sp_arbiter: RTL and testbench
=================================

Name: mem_sp_arbiter

Overview:
- Shares one single-port table (memory_sp instance, 1-cycle read latency) between NUM_REQ requesters inside blockB-class modules.
- Clears the table after reset, then grants one access per cycle round-robin.
- Returns read data to the requester that issued the read.
- Sits between requester sub-blocks and the memory_sp instance and drives its port directly.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- DEPTH, 32, table entries; BSIZE at instantiation
- DATA_W, 16, entry width; $bits(seeSt) at instantiation
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden)
- INIT_VAL, 0, value written to every entry during the init sweep

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_vld  in  NUM_REQ  per-requester request valid
- req_rdy  out  NUM_REQ  per-requester grant; transfer when vld&rdy
- req_we  in  NUM_REQ  1=write, 0=read
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- rsp_vld  out  NUM_REQ  one-hot read-response strobe
- rsp_data  out  DATA_W  read data, valid when any rsp_vld bit is set
- init_done  out  1  high once the init sweep completes
- mem_cs  out  1  memory chip select
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read with cs=1, we=0

Behaviour:
- Reset values:
  - req_rdy=0, rsp_vld=0, rsp_data=0, init_done=0.
  - mem_cs=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Round-robin pointer=0, init counter=0, state=INIT.
- State INIT:
  - Each cycle: mem_cs=1, mem_we=1, mem_addr=cnt, mem_wdata=INIT_VAL; cnt increments.
  - req_rdy=0 throughout.
  - At cnt==DEPTH-1, the write occurs and the state moves to RUN; init_done rises the next cycle.
  - The sweep takes exactly DEPTH cycles. init_done stays high until reset.
- State RUN:
  - Combinational round-robin arbitration over req_vld, starting at the pointer.
  - At most one req_rdy bit is set, and only for a requester with req_vld=1. All bits are 0 if nothing is valid.
  - On grant g: mem_cs=1, mem_we=req_we[g], mem_addr/mem_wdata = slice g, driven combinationally in the same cycle.
  - Pointer becomes (g+1) mod NUM_REQ. The pointer holds when there is no grant.
  - Read granted at cycle t: rsp_vld[g]=1 at t+1, with rsp_data=mem_rdata registered through. Latency is 1 cycle.
  - Responses have no backpressure; the requester must accept them.
  - A write produces no response.
  - Back-to-back accesses are allowed every cycle, including a read followed by a write to the same address. That read returns the old data, per memory_sp semantics.
  - Idle cycles: mem_cs=0. mem_addr/mem_wdata hold their last values; they are don't-care.
  - Fairness: a requester that holds vld waits at most NUM_REQ-1 grants.
- Requester rules:
  - A requester holds vld and payload stable until rdy.
  - The arbiter may legally drop rdy while vld remains high.
- Reset mid-operation:
  - All outputs return to reset values immediately (asynchronous).
  - An in-flight read response is discarded.
  - The INIT sweep restarts from 0.
- Requests arriving during INIT stall; none is lost.

Decomposition:
- Shared package (mixed_package):
  - MEM_ARB_NUM_REQ constant.
  - memArbStateT enum {INIT, RUN}.
  - Optional memArbReqSt typedef {we, addr, wdata} for callers using rdy_vld_if wrappers.
- Sub-module rr_arbiter: parameter N, inputs req/advance, output one-hot grant. Reusable by other blockB-class schedulers.

Test Plan:
- Reset, DEPTH=32 -> mem_we=1 for 32 consecutive cycles with addresses 0..31 and data 0; init_done=1 on cycle 33; req_rdy=0 during sweep.
- After init, req0 writes addr 5 = 0xBEEF, then req1 reads addr 5 -> rsp_vld=3'b010 one cycle after grant, rsp_data=0xBEEF; req1 reading addr 6 returns 0.
- All three requesters hold vld for 9 cycles -> grant order 0,1,2,0,1,2,0,1,2; each gets exactly 3 grants.
- Only req2 valid for 4 cycles -> 4 consecutive grants to req2; a later simultaneous req0+req1 grants req0 first (pointer wrapped to 0).
- Read addr 7 (old 0x0001) granted at t, write addr 7 = 0x0002 granted at t+1, read addr 7 at t+2 -> responses 0x0001 at t+1, 0x0002 at t+3.
- rst_n asserted the cycle after a read grant -> no rsp_vld; after release, a full 32-cycle sweep; previously written 0xBEEF at addr 5 reads back 0.

Source files
------------

// File: rtl/mem_sp_arbiter_pkg.sv
// Shared definitions for the single-port table arbiter and its callers:
// requester count, FSM state type, an optional request payload struct and a
// small modular-add helper used by the round-robin search.
package mem_sp_arbiter_pkg;

  // Default number of requesters sharing one table.
  localparam int MEM_ARB_NUM_REQ = 3;

  // Default table geometry, used only to size the optional request struct.
  localparam int MEM_ARB_DEPTH  = 32;
  localparam int MEM_ARB_DATA_W = 16;
  localparam int MEM_ARB_ADDR_W = $clog2(MEM_ARB_DEPTH);

  // INIT clears the table after reset; RUN serves requesters.
  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } memArbStateT;

  // Request payload for callers wrapping the arbiter in rdy/vld interfaces.
  typedef struct packed {
    logic                      we;
    logic [MEM_ARB_ADDR_W-1:0] addr;
    logic [MEM_ARB_DATA_W-1:0] wdata;
  } memArbReqSt;

  // (base + off) mod n, assuming base < n and off < n.
  function automatic int rr_wrap(input int base, input int off, input int n);
    int s;
    s = base + off;
    if (s >= n) begin
      s = s - n;
    end
    return s;
  endfunction

endpackage

// File: rtl/mem_sp_arbiter_rr_arbiter.sv
// Generic round-robin arbiter. Searches req starting at an internal pointer,
// returns a one-hot grant plus its index, and moves the pointer one past the
// winner whenever advance is high and a grant was issued.
module rr_arbiter
  import mem_sp_arbiter_pkg::*;
#(
  parameter  int N     = 3,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;

  // Candidate index for each search position: cand[k] = (ptr + k) mod N.
  logic [IDX_W-1:0] cand [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
      assign cand[gi] = IDX_W'(rr_wrap(int'(ptr_q), gi, N));
    end
  endgenerate

  // Pick the first asserted request at or after the pointer; scanning from the
  // far end lets the closest candidate overwrite earlier hits.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        grant           = '0;
        grant[cand[k]]  = 1'b1;
        grant_idx       = cand[k];
        grant_any       = 1'b1;
      end
    end
  end

  // Next pointer: one past the winner, wrapping; holds when nothing is granted.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && grant_any) begin
      if (grant_idx == IDX_W'(N - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx + 1'b1;
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mem_sp_arbiter.sv
// Shares one single-port table (1-cycle read latency) between NUM_REQ
// requesters. After reset the whole table is written with INIT_VAL, one entry
// per cycle; afterwards one access per cycle is granted round-robin and read
// data is steered back to the requester that issued the read.
module mem_sp_arbiter
  import mem_sp_arbiter_pkg::*;
#(
  parameter  int                NUM_REQ  = MEM_ARB_NUM_REQ,
  parameter  int                DEPTH    = 32,
  parameter  int                DATA_W   = 16,
  parameter  logic [DATA_W-1:0] INIT_VAL = '0,
  localparam int                ADDR_W   = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_vld,
  output logic [NUM_REQ-1:0]          req_rdy,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          rsp_vld,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        init_done,
  output logic                        mem_cs,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int              IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  memArbStateT        state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic               init_done_q, init_done_d;
  logic [NUM_REQ-1:0] rsp_vld_q, rsp_vld_d;
  logic [ADDR_W-1:0]  addr_hold_q, addr_hold_d;
  logic [DATA_W-1:0]  wdata_hold_q, wdata_hold_d;

  // Per-requester views of the packed address and write-data buses.
  logic [ADDR_W-1:0]  addr_slice  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_slice [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_slice[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_slice[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Requests are only visible to the arbiter once the sweep is finished, so
  // anything raised during INIT simply waits with vld held high.
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               arb_advance;

  assign arb_req     = (state_q == RUN) ? req_vld : '0;
  assign arb_advance = (state_q == RUN);

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (arb_req),
    .advance   (arb_advance),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_any (arb_any)
  );

  assign req_rdy   = arb_grant;
  assign rsp_vld   = rsp_vld_q;
  assign init_done = init_done_q;

  // The table returns data one cycle after the read; pass it through only on a
  // response cycle so the output reads zero otherwise.
  assign rsp_data  = (|rsp_vld_q) ? mem_rdata : '0;

  // Next-state and memory port drive: sweep writes in INIT, granted access in
  // RUN. While reset is held the port is forced quiet.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    rsp_vld_d   = '0;
    mem_cs      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = addr_hold_q;
    mem_wdata   = wdata_hold_q;

    unique case (state_q)
      INIT: begin
        mem_cs    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = cnt_q;
        mem_wdata = INIT_VAL;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          cnt_d       = '0;
          state_d     = RUN;
          init_done_d = 1'b1;
        end
      end
      RUN: begin
        if (arb_any) begin
          mem_cs    = 1'b1;
          mem_we    = req_we[arb_idx];
          mem_addr  = addr_slice[arb_idx];
          mem_wdata = wdata_slice[arb_idx];
          // Only reads produce a response, tagged with the granted requester.
          if (!req_we[arb_idx]) begin
            rsp_vld_d = arb_grant;
          end
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase

    if (!rst_n) begin
      mem_cs    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  // Idle cycles keep presenting the last address/data to avoid needless toggling.
  assign addr_hold_d  = mem_addr;
  assign wdata_hold_d = mem_wdata;

  // State, sweep counter, response strobe and port-hold registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= INIT;
      cnt_q        <= '0;
      init_done_q  <= 1'b0;
      rsp_vld_q    <= '0;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      init_done_q  <= init_done_d;
      rsp_vld_q    <= rsp_vld_d;
      addr_hold_q  <= addr_hold_d;
      wdata_hold_q <= wdata_hold_d;
    end
  end

endmodule

// File: tb/tb_mem_sp_arbiter.sv
// Directed testbench for mem_sp_arbiter with a behavioural single-port table
// (read returns old data, 1-cycle latency). Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge.
module tb_mem_sp_arbiter;

  localparam int NUM_REQ = 3;
  localparam int DEPTH   = 32;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 5;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [NUM_REQ-1:0]        req_vld = '0;
  logic [NUM_REQ-1:0]        req_rdy;
  logic [NUM_REQ-1:0]        req_we = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
  logic [NUM_REQ*DATA_W-1:0] req_wdata = '0;
  logic [NUM_REQ-1:0]        rsp_vld;
  logic [DATA_W-1:0]         rsp_data;
  logic                      init_done;
  logic                      mem_cs;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata = '0;

  logic [DATA_W-1:0]         mem_model [DEPTH];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_sp_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .DEPTH    (DEPTH),
    .DATA_W   (DATA_W),
    .INIT_VAL (16'h0000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_vld   (req_vld),
    .req_rdy   (req_rdy),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_vld   (rsp_vld),
    .rsp_data  (rsp_data),
    .init_done (init_done),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Table model; while reset is low it is filled with junk so the sweep must clear it.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_model[i] <= 16'hDEAD;
    end else if (mem_cs) begin
      if (mem_we) mem_model[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_model[mem_addr];
    end
  end

  // One line per granted access after init.
  always @(negedge clk) begin
    if (rst_n && init_done && mem_cs)
      $display("[TB] t=%0t access %s rdy=%b addr=%0d wdata=%h", $time,
               mem_we ? "WR" : "RD", req_rdy, mem_addr, mem_wdata);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    req_vld   = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic drive(input int r, input logic we, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] data);
    req_vld[r]                  = 1'b1;
    req_we[r]                   = we;
    req_addr[r*ADDR_W +: ADDR_W] = addr;
    req_wdata[r*DATA_W +: DATA_W] = data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_reqs();
    repeat (3) step();
    sample();
    tests++;
    if ({req_rdy, rsp_vld, init_done} !== 7'b0) begin
      fails++;
      $display("FAIL reset_ctrl: rdy=%b rsp_vld=%b init_done=%b expected 000/000/0",
               req_rdy, rsp_vld, init_done);
    end
    tests++;
    if (rsp_data !== 16'h0000) begin
      fails++;
      $display("FAIL reset_rsp_data: got %h expected 0000", rsp_data);
    end
    tests++;
    if ({mem_cs, mem_we, mem_addr, mem_wdata} !== 23'b0) begin
      fails++;
      $display("FAIL reset_mem: cs=%b we=%b addr=%0d wdata=%h expected all 0",
               mem_cs, mem_we, mem_addr, mem_wdata);
    end
    step();
  endtask

  // Expects rst_n to have just been released; checks the 32 sweep writes.
  task automatic test_init_sweep(input int pass);
    for (int c = 0; c < DEPTH; c++) begin
      sample();
      tests++;
      if ({mem_cs, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 5'(c), 16'h0000}) begin
        fails++;
        $display("FAIL sweep%0d_c%0d: cs/we/addr/wdata=%b/%b/%0d/%h expected 1/1/%0d/0000",
                 pass, c, mem_cs, mem_we, mem_addr, mem_wdata, c);
      end
      tests++;
      if ({req_rdy, init_done} !== 4'b0000) begin
        fails++;
        $display("FAIL sweep%0d_stall_c%0d: rdy=%b init_done=%b expected 000/0",
                 pass, c, req_rdy, init_done);
      end
      step();
    end
  endtask

  task automatic test_first_access_after_init();
    // req0 has held a read of addr 9 throughout the sweep.
    sample();
    tests++;
    if (init_done !== 1'b1) begin
      fails++;
      $display("FAIL init_done_rise: got %b expected 1", init_done);
    end
    tests++;
    if ({req_rdy, mem_cs, mem_we, mem_addr} !== {3'b001, 1'b1, 1'b0, 5'd9}) begin
      fails++;
      $display("FAIL stalled_req_grant: rdy=%b cs=%b we=%b addr=%0d expected 001/1/0/9",
               req_rdy, mem_cs, mem_we, mem_addr);
    end
    step();
    clear_reqs();
    sample();
    tests++;
    if ({rsp_vld, rsp_data} !== {3'b001, 16'h0000}) begin
      fails++;
      $display("FAIL cleared_entry: rsp_vld=%b data=%h expected 001/0000", rsp_vld, rsp_data);
    end
    step();
  endtask

  task automatic test_write_read();
    drive(0, 1'b1, 5'd5, 16'hBEEF);
    sample();
    tests++;
    if ({req_rdy, mem_cs, mem_we, mem_addr, mem_wdata} !== {3'b001, 1'b1, 1'b1, 5'd5, 16'hBEEF}) begin
      fails++;
      $display("FAIL wr_grant: rdy=%b cs=%b we=%b addr=%0d wdata=%h expected 001/1/1/5/beef",
               req_rdy, mem_cs, mem_we, mem_addr, mem_wdata);
    end
    step();
    clear_reqs();
    drive(1, 1'b0, 5'd5, 16'h0000);
    sample();
    tests++;
    if ({req_rdy, mem_cs, mem_we, mem_addr} !== {3'b010, 1'b1, 1'b0, 5'd5}) begin
      fails++;
      $display("FAIL rd5_grant: rdy=%b cs=%b we=%b addr=%0d expected 010/1/0/5",
               req_rdy, mem_cs, mem_we, mem_addr);
    end
    tests++;
    if (rsp_vld !== 3'b000) begin
      fails++;
      $display("FAIL wr_no_rsp: rsp_vld=%b expected 000", rsp_vld);
    end
    step();
    drive(1, 1'b0, 5'd6, 16'h0000);
    sample();
    tests++;
    if ({rsp_vld, rsp_data} !== {3'b010, 16'hBEEF}) begin
      fails++;
      $display("FAIL rd5_rsp: rsp_vld=%b data=%h expected 010/beef", rsp_vld, rsp_data);
    end
    tests++;
    if ({req_rdy, mem_addr} !== {3'b010, 5'd6}) begin
      fails++;
      $display("FAIL rd6_grant: rdy=%b addr=%0d expected 010/6", req_rdy, mem_addr);
    end
    step();
    clear_reqs();
    sample();
    tests++;
    if ({rsp_vld, rsp_data} !== {3'b010, 16'h0000}) begin
      fails++;
      $display("FAIL rd6_rsp: rsp_vld=%b data=%h expected 010/0000", rsp_vld, rsp_data);
    end
    tests++;
    if ({mem_cs, req_rdy} !== 4'b0000) begin
      fails++;
      $display("FAIL idle_cs: cs=%b rdy=%b expected 0/000", mem_cs, req_rdy);
    end
    step();
    sample();
    tests++;
    if (rsp_vld !== 3'b000) begin
      fails++;
      $display("FAIL idle_rsp: rsp_vld=%b expected 000", rsp_vld);
    end
    step();
  endtask

  // Pointer is 2 here; req2 alone is granted 4 times and the pointer wraps to 0.
  task automatic test_single_requester();
    drive(2, 1'b0, 5'd10, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      sample();
      tests++;
      if (req_rdy !== 3'b100) begin
        fails++;
        $display("FAIL solo_req2_k%0d: rdy=%b expected 100", k, req_rdy);
      end
      if (k > 0) begin
        tests++;
        if (rsp_vld !== 3'b100) begin
          fails++;
          $display("FAIL solo_rsp_k%0d: rsp_vld=%b expected 100", k, rsp_vld);
        end
      end
      step();
    end
    clear_reqs();
  endtask

  task automatic test_fairness();
    int cnt [NUM_REQ];
    logic [2:0] exp_g;
    logic [2:0] exp_r;
    for (int i = 0; i < NUM_REQ; i++) cnt[i] = 0;
    for (int i = 0; i < NUM_REQ; i++) drive(i, 1'b0, 5'(i), 16'h0000);
    for (int k = 0; k < 9; k++) begin
      sample();
      exp_g = 3'b001 << (k % 3);
      tests++;
      if (req_rdy !== exp_g) begin
        fails++;
        $display("FAIL rr_order_k%0d: rdy=%b expected %b", k, req_rdy, exp_g);
      end
      if (k > 0) begin
        exp_r = 3'b001 << ((k - 1) % 3);
        tests++;
        if (rsp_vld !== exp_r) begin
          fails++;
          $display("FAIL rr_rsp_k%0d: rsp_vld=%b expected %b", k, rsp_vld, exp_r);
        end
      end
      for (int i = 0; i < NUM_REQ; i++) if (req_rdy[i] === 1'b1) cnt[i]++;
      step();
    end
    clear_reqs();
    for (int i = 0; i < NUM_REQ; i++) begin
      tests++;
      if (cnt[i] != 3) begin
        fails++;
        $display("FAIL rr_count_req%0d: got %0d grants expected 3", i, cnt[i]);
      end
    end
  endtask

  // Pointer wrapped to 0: req0+req1 together -> req0 first, then req1.
  task automatic test_pair_after_wrap();
    drive(0, 1'b0, 5'd1, 16'h0000);
    drive(1, 1'b0, 5'd2, 16'h0000);
    sample();
    tests++;
    if (req_rdy !== 3'b001) begin
      fails++;
      $display("FAIL pair_first: rdy=%b expected 001", req_rdy);
    end
    step();
    req_vld[0] = 1'b0;
    sample();
    tests++;
    if (req_rdy !== 3'b010) begin
      fails++;
      $display("FAIL pair_second: rdy=%b expected 010", req_rdy);
    end
    step();
    clear_reqs();
  endtask

  // Pointer is 2: req2 primes addr 7 = 0x0001, then read/write/read on addr 7.
  task automatic test_back_to_back();
    drive(2, 1'b1, 5'd7, 16'h0001);
    sample();
    tests++;
    if (req_rdy !== 3'b100) begin
      fails++;
      $display("FAIL b2b_prime: rdy=%b expected 100", req_rdy);
    end
    step();
    clear_reqs();
    drive(0, 1'b0, 5'd7, 16'h0000);
    sample();
    tests++;
    if (req_rdy !== 3'b001) begin
      fails++;
      $display("FAIL b2b_rd_t: rdy=%b expected 001", req_rdy);
    end
    step();
    clear_reqs();
    drive(1, 1'b1, 5'd7, 16'h0002);
    sample();
    tests++;
    if ({req_rdy, mem_we, mem_wdata} !== {3'b010, 1'b1, 16'h0002}) begin
      fails++;
      $display("FAIL b2b_wr_t1: rdy=%b we=%b wdata=%h expected 010/1/0002",
               req_rdy, mem_we, mem_wdata);
    end
    tests++;
    if ({rsp_vld, rsp_data} !== {3'b001, 16'h0001}) begin
      fails++;
      $display("FAIL b2b_old_data: rsp_vld=%b data=%h expected 001/0001", rsp_vld, rsp_data);
    end
    step();
    clear_reqs();
    drive(2, 1'b0, 5'd7, 16'h0000);
    sample();
    tests++;
    if ({req_rdy, rsp_vld} !== {3'b100, 3'b000}) begin
      fails++;
      $display("FAIL b2b_rd_t2: rdy=%b rsp_vld=%b expected 100/000", req_rdy, rsp_vld);
    end
    step();
    clear_reqs();
    sample();
    tests++;
    if ({rsp_vld, rsp_data} !== {3'b100, 16'h0002}) begin
      fails++;
      $display("FAIL b2b_new_data: rsp_vld=%b data=%h expected 100/0002", rsp_vld, rsp_data);
    end
    step();
  endtask

  // Pointer is 0: read of addr 5 granted, reset hits the next cycle.
  task automatic test_reset_mid();
    drive(0, 1'b0, 5'd5, 16'h0000);
    sample();
    tests++;
    if (req_rdy !== 3'b001) begin
      fails++;
      $display("FAIL mid_rd_grant: rdy=%b expected 001", req_rdy);
    end
    step();
    rst_n = 1'b0;
    clear_reqs();
    #1;
    tests++;
    if ({rsp_vld, rsp_data, init_done, mem_cs} !== 21'b0) begin
      fails++;
      $display("FAIL mid_async_clear: rsp_vld=%b data=%h init_done=%b cs=%b expected all 0",
               rsp_vld, rsp_data, init_done, mem_cs);
    end
    for (int k = 0; k < 2; k++) begin
      sample();
      tests++;
      if ({rsp_vld, req_rdy, mem_cs} !== 7'b0) begin
        fails++;
        $display("FAIL mid_hold_k%0d: rsp_vld=%b rdy=%b cs=%b expected 000/000/0",
                 k, rsp_vld, req_rdy, mem_cs);
      end
      step();
    end
    rst_n = 1'b1;
    test_init_sweep(2);
    drive(1, 1'b0, 5'd5, 16'h0000);
    sample();
    tests++;
    if ({init_done, req_rdy} !== {1'b1, 3'b010}) begin
      fails++;
      $display("FAIL mid_rearm: init_done=%b rdy=%b expected 1/010", init_done, req_rdy);
    end
    step();
    clear_reqs();
    sample();
    tests++;
    if ({rsp_vld, rsp_data} !== {3'b010, 16'h0000}) begin
      fails++;
      $display("FAIL mid_beef_cleared: rsp_vld=%b data=%h expected 010/0000", rsp_vld, rsp_data);
    end
    step();
  endtask

  initial begin
    test_reset();
    drive(0, 1'b0, 5'd9, 16'h0000);
    rst_n = 1'b1;
    test_init_sweep(1);
    test_first_access_after_init();
    test_write_read();
    test_single_requester();
    test_fairness();
    test_pair_after_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
